// File: rtl/multicycle_pkg.sv
// Shared constants and types for the multi-cycle control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multicycle_pkg;

  // Opcode field values (ins[INS_W-1 -: 6])
  localparam logic [5:0] OP_ROLV = 6'b000000;
  localparam logic [5:0] OP_RORV = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_NOTR = 6'b000100;
  localparam logic [5:0] OP_JR   = 6'b001000;
  localparam logic [5:0] OP_NORI = 6'b001110;
  localparam logic [5:0] OP_BLEU = 6'b010000;
  localparam logic [5:0] OP_ANDR = 6'b100000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_NORR = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b101011;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_R_EX,
    S_R_WB,
    S_I_EX,
    S_I_WB,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_FAULT
  } state_t;

  typedef enum logic [4:0] {
    ALU_AND = 5'd0,
    ALU_NOR = 5'd1,
    ALU_ROL = 5'd2,
    ALU_ROR = 5'd3,
    ALU_ADD = 5'd4,
    ALU_LEU = 5'd5
  } alu_op_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LW,
    CLS_SW,
    CLS_BR,
    CLS_JR,
    CLS_JAL,
    CLS_ILL
  } ins_class_t;

  // PC source select
  localparam logic [1:0] PC_SRC_PC4    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;

  // ALU B operand select
  localparam logic [1:0] SRC_B_RT   = 2'd0;
  localparam logic [1:0] SRC_B_SEXT = 2'd1;
  localparam logic [1:0] SRC_B_ZEXT = 2'd2;
  localparam logic [1:0] SRC_B_ZERO = 2'd3;

  // Register file destination select
  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_R31 = 2'd2;

endpackage

// File: rtl/opcode_decode.sv
// Opcode decoder: maps the 6-bit opcode to an instruction class and ALU operation.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the opcode.
module opcode_decode
  import multicycle_pkg::*;
(
  input  logic [5:0] opcode,
  output ins_class_t ins_class,
  output alu_op_t    alu_op,
  output logic       use_zero_b,
  output logic       illegal
);

  // Classify the opcode; any encoding not listed is illegal.
  always_comb begin
    ins_class  = CLS_ILL;
    alu_op     = ALU_AND;
    use_zero_b = 1'b0;
    case (opcode)
      OP_ANDR: begin ins_class = CLS_R;   alu_op = ALU_AND; end
      OP_NORR: begin ins_class = CLS_R;   alu_op = ALU_NOR; end
      // notr is rs NOR 0, so the B operand is forced to zero
      OP_NOTR: begin ins_class = CLS_R;   alu_op = ALU_NOR; use_zero_b = 1'b1; end
      OP_ROLV: begin ins_class = CLS_R;   alu_op = ALU_ROL; end
      OP_RORV: begin ins_class = CLS_R;   alu_op = ALU_ROR; end
      OP_NORI: begin ins_class = CLS_I;   alu_op = ALU_NOR; end
      OP_LW:   begin ins_class = CLS_LW;  alu_op = ALU_ADD; end
      OP_SW:   begin ins_class = CLS_SW;  alu_op = ALU_ADD; end
      OP_BLEU: begin ins_class = CLS_BR;  alu_op = ALU_LEU; end
      OP_JR:   begin ins_class = CLS_JR;  end
      OP_JAL:  begin ins_class = CLS_JAL; end
      default: begin ins_class = CLS_ILL; end
    endcase
  end

  assign illegal = (ins_class == CLS_ILL);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath controls.
// Latency: R/I 4, lw 5, sw 4, bleu 3, jr/jal 3 cycles with zero-wait memory.
// Backpressure: holds mem_req until mem_ready; MEM_TIMEOUT stalled cycles in one request -> sticky FAULT.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int INS_W       = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [INS_W-1:0] ins,
  input  logic             mem_ready,
  input  logic             cmp_le,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [4:0]       alu_op,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       reg_dst,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             fault,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q;
  logic              mem_wait;
  logic              timeout_hit;
  logic              retire;

  ins_class_t        dec_class;
  alu_op_t           dec_alu_op;
  logic              dec_zero_b;
  logic              dec_illegal;
  logic              unused_ins_bits;

  opcode_decode u_dec (
    .opcode     (ins[INS_W-1 -: 6]),
    .ins_class  (dec_class),
    .alu_op     (dec_alu_op),
    .use_zero_b (dec_zero_b),
    .illegal    (dec_illegal)
  );

  // Only the opcode field steers control; operand fields belong to the datapath.
  assign unused_ins_bits = ^ins[INS_W-7:0];

  // A memory-facing state that did not get its handshake this cycle.
  assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR))
                    && !mem_ready;
  // This stalled cycle is the MEM_TIMEOUT-th one; a ready in the same cycle never reaches here.
  assign timeout_hit = mem_wait && (wcnt_q == WCNT_LAST);

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Wait counter: counts stalled cycles of the current request, cleared otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      wcnt_q <= '0;
    else if (mem_wait) wcnt_q <= wcnt_q + WCNT_W'(1);
    else               wcnt_q <= '0;
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_PC4;
    alu_op     = ALU_AND;
    alu_src_b  = SRC_B_RT;
    reg_dst    = DST_RT;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    fault      = (state_q == S_FAULT);
    busy       = (state_q != S_IDLE) && (state_q != S_FAULT);

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_SRC_PC4;
          state_d  = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end
      end

      S_DECODE: begin
        if (dec_illegal) begin
          state_d = S_FAULT;
        end else begin
          case (dec_class)
            CLS_R:            state_d = S_R_EX;
            CLS_I:            state_d = S_I_EX;
            CLS_LW, CLS_SW:   state_d = S_MEM_ADDR;
            CLS_BR:           state_d = S_BRANCH;
            CLS_JR, CLS_JAL:  state_d = S_JUMP;
            default:          state_d = S_FAULT;
          endcase
        end
      end

      S_R_EX: begin
        alu_op    = dec_alu_op;
        alu_src_b = dec_zero_b ? SRC_B_ZERO : SRC_B_RT;
        state_d   = S_R_WB;
      end

      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = DST_RD;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_I_EX: begin
        alu_op    = ALU_NOR;
        alu_src_b = SRC_B_ZEXT;
        state_d   = S_I_WB;
      end

      S_I_WB: begin
        reg_write = 1'b1;
        reg_dst   = DST_RT;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_op    = ALU_ADD;
        alu_src_b = SRC_B_SEXT;
        state_d   = (dec_class == CLS_SW) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        mem_req = 1'b1;
        if (mem_ready)        state_d = S_MEM_WB;
        else if (timeout_hit) state_d = S_FAULT;
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        reg_dst    = DST_RT;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end
      end

      S_BRANCH: begin
        alu_op   = ALU_LEU;
        pc_write = cmp_le;
        pc_src   = PC_SRC_BRANCH;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end

      S_JUMP: begin
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
        if (dec_class == CLS_JAL) begin
          pc_src    = PC_SRC_JUMP;
          reg_write = 1'b1;
          reg_dst   = DST_R31;
        end else begin
          pc_src = PC_SRC_RS;
        end
      end

      // Sticky until reset: every enable stays low.
      S_FAULT: state_d = S_FAULT;

      default: state_d = S_FAULT;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: vector table, random instruction stream, corner sequences.
// Latency: expected per-cycle controls and instruction latencies come from the bench's own instruction model.
// Backpressure: memory wait states are injected per request; timeout and reset-abort are hand sequences.
module tb_multicycle_control;

  localparam int INS_W       = 32;
  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 16;

  localparam logic [5:0] ROLV = 6'b000000, RORV = 6'b000010, JAL  = 6'b000011,
                         NOTR = 6'b000100, JR   = 6'b001000, NORI = 6'b001110,
                         BLEU = 6'b010000, ANDR = 6'b100000, LW   = 6'b100011,
                         NORR = 6'b100110, SW   = 6'b101011, BAD  = 6'b111111;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [4:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       fault;
    logic       busy;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    int         wf;
    int         wd;
    logic       cl;
    int         lat;
    string      nm;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [INS_W-1:0] ins = '0;
  logic             mem_ready = 1'b0;
  logic             cmp_le = 1'b0;
  logic             mem_req, mem_we, ir_write, pc_write, reg_write, mem_to_reg, fault, busy;
  logic [1:0]       pc_src, alu_src_b, reg_dst;
  logic [4:0]       alu_op;
  logic [CNT_W-1:0] retired;
  outs_t            act;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;
  int ncyc, lat_meas;
  bit lat_done;
  logic [CNT_W-1:0] r_start;

  multicycle_control #(.INS_W(INS_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ins        (ins),
    .mem_ready  (mem_ready),
    .cmp_le     (cmp_le),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .alu_src_b  (alu_src_b),
    .reg_dst    (reg_dst),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .fault      (fault),
    .busy       (busy),
    .retired    (retired)
  );

  assign act = {mem_req, mem_we, ir_write, pc_write, pc_src, alu_op, alu_src_b,
                reg_dst, reg_write, mem_to_reg, fault, busy};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic outs_t busy_o();
    outs_t o;
    o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  // Instruction latency with wf fetch stalls and wd data stalls.
  function automatic int model_lat(input logic [5:0] op, input int wf, input int wd);
    case (op)
      LW:            return 5 + wf + wd;
      SW:            return 4 + wf + wd;
      BLEU, JR, JAL: return 3 + wf;
      default:       return 4 + wf;
    endcase
  endfunction

  task automatic chk_outs(input outs_t e, input string nm);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: outputs got %h expected %h", nm, act, e);
    end
  endtask

  task automatic chk_val(input longint a, input longint e, input string nm);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  // One cycle: drive inputs after the edge, compare mid-cycle, then advance and note retirement.
  task automatic cyc(input logic mr, input logic cl, input outs_t e, input string nm);
    mem_ready = mr;
    cmp_le    = cl;
    @(negedge clk);
    chk_outs(e, nm);
    @(posedge clk);
    #1;
    ncyc++;
    if (!lat_done && retired != r_start) begin
      lat_done = 1'b1;
      lat_meas = ncyc;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    cmp_le    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_outs('0, "reset_outs");
    chk_val(retired, 0, "reset_retired");
    reset_n = 1'b1;
    exp_ret = 0;
    cyc(rb(), rb(), '0, "idle");
  endtask

  // Run one legal instruction with the given stall counts and check every cycle plus retirement.
  task automatic run_ins(input logic [5:0] op, input int wf, input int wd, input logic cl,
                         input int exp_lat, input string nm);
    outs_t o;
    logic [25:0] lo;
    lo = 26'($urandom);
    ins = {op, lo};
    r_start  = retired;
    lat_done = 1'b0;
    lat_meas = 0;
    ncyc     = 0;
    for (int k = 0; k <= wf; k++) begin
      o = busy_o();
      o.mem_req = 1'b1;
      if (k == wf) begin
        o.ir_write = 1'b1;
        o.pc_write = 1'b1;
      end
      cyc(k == wf, rb(), o, {nm, "_fetch"});
    end
    cyc(rb(), rb(), busy_o(), {nm, "_decode"});
    case (op)
      LW, SW: begin
        o = busy_o(); o.alu_op = 5'd4; o.alu_src_b = 2'd1;
        cyc(rb(), rb(), o, {nm, "_addr"});
        for (int k = 0; k <= wd; k++) begin
          o = busy_o(); o.mem_req = 1'b1; o.mem_we = (op == SW);
          cyc(k == wd, rb(), o, {nm, "_mem"});
        end
        if (op == LW) begin
          o = busy_o(); o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
          cyc(rb(), rb(), o, {nm, "_wb"});
        end
      end
      BLEU: begin
        o = busy_o(); o.alu_op = 5'd5; o.pc_write = cl; o.pc_src = 2'd1;
        cyc(rb(), cl, o, {nm, "_branch"});
      end
      JR: begin
        o = busy_o(); o.pc_write = 1'b1; o.pc_src = 2'd3;
        cyc(rb(), rb(), o, {nm, "_jump"});
      end
      JAL: begin
        o = busy_o(); o.pc_write = 1'b1; o.pc_src = 2'd2; o.reg_write = 1'b1; o.reg_dst = 2'd2;
        cyc(rb(), rb(), o, {nm, "_jump"});
      end
      NORI: begin
        o = busy_o(); o.alu_op = 5'd1; o.alu_src_b = 2'd2;
        cyc(rb(), rb(), o, {nm, "_ex"});
        o = busy_o(); o.reg_write = 1'b1;
        cyc(rb(), rb(), o, {nm, "_wb"});
      end
      default: begin
        o = busy_o();
        o.alu_op    = (op == ANDR) ? 5'd0 : (op == ROLV) ? 5'd2 : (op == RORV) ? 5'd3 : 5'd1;
        o.alu_src_b = (op == NOTR) ? 2'd3 : 2'd0;
        cyc(rb(), rb(), o, {nm, "_ex"});
        o = busy_o(); o.reg_write = 1'b1; o.reg_dst = 2'd1;
        cyc(rb(), rb(), o, {nm, "_wb"});
      end
    endcase
    exp_ret = (exp_ret + 1) % (1 << CNT_W);
    chk_val(retired, exp_ret, {nm, "_retired"});
    chk_val(lat_done ? lat_meas : -1, exp_lat, {nm, "_latency"});
  endtask

  initial begin
    vec_t       tbl[$];
    logic [5:0] legal[11];
    outs_t      o;
    outs_t      fo;
    int         keep;

    legal = '{ROLV, RORV, JAL, NOTR, JR, NORI, BLEU, ANDR, LW, NORR, SW};
    fo = '0;
    fo.fault = 1'b1;

    tbl.push_back('{ANDR, 0,  0,  1'b0, 4,  "andr"});
    tbl.push_back('{NORR, 1,  0,  1'b0, 5,  "norr_wait1"});
    tbl.push_back('{NOTR, 0,  0,  1'b0, 4,  "notr"});
    tbl.push_back('{ROLV, 2,  0,  1'b0, 6,  "rolv_wait2"});
    tbl.push_back('{RORV, 0,  0,  1'b0, 4,  "rorv"});
    tbl.push_back('{NORI, 0,  0,  1'b0, 4,  "nori"});
    tbl.push_back('{LW,   0,  3,  1'b0, 8,  "lw_wait3"});
    tbl.push_back('{LW,   0,  0,  1'b0, 5,  "lw"});
    tbl.push_back('{SW,   0,  0,  1'b0, 4,  "sw"});
    tbl.push_back('{SW,   2,  1,  1'b0, 7,  "sw_waits"});
    tbl.push_back('{BLEU, 0,  0,  1'b1, 3,  "bleu_taken"});
    tbl.push_back('{BLEU, 0,  0,  1'b0, 3,  "bleu_not"});
    tbl.push_back('{JAL,  0,  0,  1'b0, 3,  "jal"});
    tbl.push_back('{JR,   0,  0,  1'b0, 3,  "jr"});
    tbl.push_back('{ANDR, 15, 0,  1'b0, 19, "fetch_ready_at_limit"});
    tbl.push_back('{LW,   0,  15, 1'b0, 20, "lw_ready_at_limit"});

    do_reset();

    foreach (tbl[i])
      run_ins(tbl[i].op, tbl[i].wf, tbl[i].wd, tbl[i].cl, tbl[i].lat, tbl[i].nm);

    // Random instruction stream against the model.
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      int wf, wd;
      logic cl;
      op = legal[$urandom_range(10, 0)];
      wf = $urandom_range(3, 0);
      wd = $urandom_range(3, 0);
      cl = rb();
      run_ins(op, wf, wd, cl, model_lat(op, wf, wd), "rand");
    end

    // Reset asserted while a store waits in MEM_WR: controls drop at once, counter clears.
    ins = {SW, 26'h0};
    ncyc = 0; lat_done = 1'b1;
    o = busy_o(); o.mem_req = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
    cyc(1'b1, rb(), o, "abort_fetch");
    cyc(rb(), rb(), busy_o(), "abort_decode");
    o = busy_o(); o.alu_op = 5'd4; o.alu_src_b = 2'd1;
    cyc(rb(), rb(), o, "abort_addr");
    mem_ready = 1'b0;
    #2;
    o = busy_o(); o.mem_req = 1'b1; o.mem_we = 1'b1;
    chk_outs(o, "abort_memwr");
    chk_val((retired != 0) ? 1 : 0, 1, "abort_retired_nonzero_before");
    reset_n = 1'b0;
    #1;
    chk_outs('0, "abort_outs");
    chk_val(retired, 0, "abort_retired");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_ret = 0;
    cyc(rb(), rb(), '0, "abort_idle");
    run_ins(ANDR, 0, 0, 1'b0, 4, "after_abort");

    // Illegal opcode: FAULT after DECODE, sticky, nothing retires.
    keep = exp_ret;
    ins = {BAD, 26'h155};
    o = busy_o(); o.mem_req = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
    cyc(1'b1, rb(), o, "illegal_fetch");
    cyc(rb(), rb(), busy_o(), "illegal_decode");
    for (int k = 0; k < 20; k++) cyc(rb(), rb(), fo, "illegal_fault");
    chk_val(retired, keep, "illegal_retired");

    // Fetch that never completes: MEM_TIMEOUT stalled cycles, then FAULT.
    do_reset();
    ins = {ANDR, 26'h0};
    o = busy_o(); o.mem_req = 1'b1;
    for (int k = 0; k < MEM_TIMEOUT; k++) cyc(1'b0, rb(), o, "timeout_wait");
    for (int k = 0; k < 4; k++) cyc(rb(), rb(), fo, "timeout_fault");
    chk_val(retired, 0, "timeout_retired");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
